// File: rtl/csr_file_tmr_if.sv
// csr_file_tmr_if: CSR access, writeback event and interrupt bundle between pipeline and CSR file
interface csr_file_tmr_if #(
  parameter int HW_INT_N = 8
);
  logic                csr_re;
  logic [13:0]         csr_num;
  logic [31:0]         csr_rdata;
  logic                csr_we;
  logic [31:0]         csr_wmask;
  logic [31:0]         csr_wdata;
  logic                ertn;
  logic                wb_ex;
  logic [5:0]          wb_ecode;
  logic [8:0]          wb_esubcode;
  logic [31:0]         wb_pc;
  logic [31:0]         wb_vaddr;
  logic [HW_INT_N-1:0] hw_int;
  logic                ipi_int;
  logic                has_int;
  logic [31:0]         ex_entry;
  logic [31:0]         era_pc;
  logic [1:0]          crmd_plv;
  logic                crmd_ie;
  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wdata, ertn, wb_ex, wb_ecode,
           wb_esubcode, wb_pc, wb_vaddr, hw_int, ipi_int,
    input  csr_rdata, has_int, ex_entry, era_pc, crmd_plv, crmd_ie
  );
  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wdata, ertn, wb_ex, wb_ecode,
           wb_esubcode, wb_pc, wb_vaddr, hw_int, ipi_int,
    output csr_rdata, has_int, ex_entry, era_pc, crmd_plv, crmd_ie
  );
endinterface

// File: rtl/csr_file_tmr.sv
// csr_file_tmr: LA32R control/status register file with local interrupt enables and countdown timer
module csr_file_tmr #(
  parameter int          NUM_SAVE   = 4,
  parameter int          TIMER_W    = 32,
  parameter int          HW_INT_N   = 8,
  parameter logic [31:0] EENTRY_RST = 32'h1c008000
) (
  input logic           clk,
  input logic           reset,
  csr_file_tmr_if.slave bus
);
  logic [1:0]          plv, pplv;
  logic                ie, da, pie;
  logic [12:0]         lie;
  logic [1:0]          is_sw;
  logic [HW_INT_N-1:0] is_hw;
  logic                is_tmr, is_ipi;
  logic [12:0]         is_all;
  logic [5:0]          ecode;
  logic [8:0]          esub;
  logic [31:0]         era, badv, tid;
  logic [25:0]         eentry;
  logic [31:0]         save [NUM_SAVE];
  logic [TIMER_W-1:0]  tcfg, tval, tcfg_new;
  logic [31:0]         wd, wm, rdata;
  logic [13:0]         num;
  logic                wr, tcfg_wr, expire, ticlr;

  function automatic logic [31:0] mw(input logic [31:0] o, input logic [31:0] d, input logic [31:0] k);
    return (o & ~k) | (d & k);
  endfunction

  assign wd       = bus.csr_wdata;
  assign wm       = bus.csr_wmask;
  assign num      = bus.csr_num;
  assign wr       = bus.csr_we & ~bus.wb_ex & ~bus.ertn;
  assign tcfg_wr  = wr & (num == 14'h41);
  assign tcfg_new = TIMER_W'(mw(32'(tcfg), wd, wm));
  assign expire   = ~tcfg_wr & tcfg[0] & (tval == '0);
  assign ticlr    = bus.csr_we & (num == 14'h44) & wd[0] & wm[0];
  assign is_all   = {is_ipi, is_tmr, 1'b0, 8'(is_hw), is_sw};

  assign bus.csr_rdata = rdata;
  assign bus.has_int   = ie & |(is_all & lie);
  assign bus.ex_entry  = {eentry, 6'b0};
  assign bus.era_pc    = era;
  assign bus.crmd_plv  = plv;
  assign bus.crmd_ie   = ie;

  // Mode/exception state: exception entry beats ertn, which beats a software write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {da, ie, plv} <= 4'h8;
      {pie, pplv}   <= 3'h0;
      ecode         <= '0;
      esub          <= '0;
      era           <= '0;
      badv          <= '0;
    end else if (bus.wb_ex) begin
      pplv  <= plv;
      pie   <= ie;
      plv   <= 2'd0;
      ie    <= 1'b0;
      ecode <= bus.wb_ecode;
      esub  <= bus.wb_esubcode;
      era   <= bus.wb_pc;
      if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) badv <= bus.wb_vaddr;
    end else if (bus.ertn) begin
      plv <= pplv;
      ie  <= pie;
    end else if (wr) begin
      if (num == 14'h0) {da, ie, plv} <= 4'(mw(32'({da, ie, plv}), wd, wm));
      if (num == 14'h1) {pie, pplv} <= 3'(mw(32'({pie, pplv}), wd, wm));
      if (num == 14'h6) era <= mw(era, wd, wm);
      if (num == 14'h7) badv <= mw(badv, wd, wm);
    end
  end

  // Plain software-writable registers; bit 10 of ECFG is reserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lie    <= '0;
      is_sw  <= '0;
      eentry <= EENTRY_RST[31:6];
      tid    <= '0;
      for (int i = 0; i < NUM_SAVE; i++) save[i] <= '0;
    end else if (wr) begin
      if (num == 14'h4) lie <= 13'(mw(32'(lie), wd, wm)) & 13'h1bff;
      if (num == 14'h5) is_sw <= 2'(mw(32'(is_sw), wd, wm));
      if (num == 14'hc) eentry <= 26'(mw({eentry, 6'b0}, wd, wm) >> 6);
      if (num == 14'h40) tid <= mw(tid, wd, wm);
      for (int i = 0; i < NUM_SAVE; i++) if (num == 14'(48 + i)) save[i] <= mw(save[i], wd, wm);
    end
  end

  // Interrupt status sampling; timer flag is sticky and a same-cycle expiry beats TICLR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_hw  <= '0;
      is_ipi <= 1'b0;
      is_tmr <= 1'b0;
    end else begin
      is_hw  <= bus.hw_int;
      is_ipi <= bus.ipi_int;
      is_tmr <= expire | (is_tmr & ~ticlr);
    end
  end

  // Countdown timer: a TCFG write reloads, otherwise count down, then reload or disarm at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg <= '0;
      tval <= '0;
    end else if (tcfg_wr) begin
      tcfg <= tcfg_new;
      tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (tcfg[0]) begin
      if (tval != '0) tval <= tval - TIMER_W'(1);
      else if (tcfg[1]) tval <= {tcfg[TIMER_W-1:2], 2'b00};
      else tcfg[0] <= 1'b0;
    end
  end

  // Combinational read mux; unimplemented addresses and idle reads return zero
  always_comb begin
    rdata = '0;
    if (bus.csr_re) begin
      case (num)
        14'h0:   rdata = {28'b0, da, ie, plv};
        14'h1:   rdata = {29'b0, pie, pplv};
        14'h4:   rdata = {19'b0, lie};
        14'h5:   rdata = {1'b0, esub, ecode, 3'b0, is_all};
        14'h6:   rdata = era;
        14'h7:   rdata = badv;
        14'hc:   rdata = {eentry, 6'b0};
        14'h40:  rdata = tid;
        14'h41:  rdata = 32'(tcfg);
        14'h42:  rdata = 32'(tval);
        default: for (int i = 0; i < NUM_SAVE; i++) if (num == 14'(48 + i)) rdata = save[i];
      endcase
    end
  end
endmodule

// File: tb/tb_csr_file_tmr.sv
// tb_csr_file_tmr: directed and randomized checks of csr_file_tmr against an address-level model
module tb_csr_file_tmr;
  localparam int          NS = 4;
  localparam int          TW = 32;
  localparam int          HN = 8;
  localparam logic [31:0] ER = 32'h1c008000;
  localparam logic [31:0] TMASK = 32'((64'd1 << TW) - 1);
  localparam logic [31:0] HMASK = 32'((64'd1 << HN) - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_file_tmr_if #(.HW_INT_N(HN)) bus();
  csr_file_tmr #(.NUM_SAVE(NS), .TIMER_W(TW), .HW_INT_N(HN), .EENTRY_RST(ER)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] m [0:68];
  logic [31:0] d;
  int n;
  int alist [18] = '{0, 1, 4, 5, 6, 7, 12, 48, 49, 50, 51, 52, 64, 65, 66, 68, 2, 100};

  function automatic logic impl(input int a);
    return (a inside {0, 1, 4, 5, 6, 7, 12, 64, 65, 66, 68}) || (a >= 48 && a < 48 + NS);
  endfunction

  function automatic logic [31:0] wmsk(input int a);
    case (a)
      0:          return 32'hF;
      1:          return 32'h7;
      4:          return 32'h1BFF;
      5:          return 32'h3;
      6, 7, 64:   return 32'hFFFFFFFF;
      12:         return 32'hFFFFFFC0;
      65:         return TMASK;
      default:    return (a >= 48 && a < 48 + NS) ? 32'hFFFFFFFF : 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input int a);
    return (a <= 68 && impl(a)) ? m[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= 68; i++) m[i] = 32'h0;
    m[0] = 32'h8;
    m[12] = ER;
  endtask

  task automatic model_cycle();
    logic [31:0] nx [0:68];
    int a;
    logic w, fire, clr, tmr;
    nx = m;
    a = int'(bus.csr_num);
    w = bus.csr_we && !bus.wb_ex && !bus.ertn;
    fire = 1'b0;
    if (bus.wb_ex) begin
      nx[1] = m[0] & 32'h7;
      nx[0] = m[0] & ~32'h7;
      nx[5] = (m[5] & 32'h1FFF) | (32'(bus.wb_ecode) << 16) | (32'(bus.wb_esubcode) << 22);
      nx[6] = bus.wb_pc;
      if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) nx[7] = bus.wb_vaddr;
    end else if (bus.ertn) begin
      nx[0] = (m[0] & ~32'h7) | (m[1] & 32'h7);
    end else if (w && impl(a)) begin
      nx[a] = (m[a] & ~(bus.csr_wmask & wmsk(a))) | (bus.csr_wdata & bus.csr_wmask & wmsk(a));
    end
    if (w && a == 65) nx[66] = nx[65] & ~32'h3;
    else if (m[65][0]) begin
      if (m[66] != 0) nx[66] = m[66] - 1;
      else begin
        fire = 1'b1;
        if (m[65][1]) nx[66] = m[65] & ~32'h3;
        else nx[65] = m[65] & ~32'h1;
      end
    end
    clr = bus.csr_we && a == 68 && bus.csr_wdata[0] && bus.csr_wmask[0];
    tmr = fire || (m[5][11] && !clr);
    nx[5] = (nx[5] & ~32'h1FFC) | ((32'(bus.hw_int) & HMASK) << 2) | (32'(tmr) << 11) | (32'(bus.ipi_int) << 12);
    m = nx;
  endtask

  task automatic cyc();
    logic hi;
    @(posedge clk);
    model_cycle();
    #1;
    hi = m[0][2] && ((m[5] & m[4] & 32'h1FFF) != 0);
    chk("has_int", 32'(bus.has_int), 32'(hi));
    chk("ex_entry", bus.ex_entry, m[12]);
    chk("era_pc", bus.era_pc, m[6]);
    chk("crmd_plv", 32'(bus.crmd_plv), m[0] & 32'h3);
    chk("crmd_ie", 32'(bus.crmd_ie), 32'(m[0][2]));
  endtask

  task automatic quiet();
    bus.csr_re = 0; bus.csr_we = 0; bus.ertn = 0; bus.wb_ex = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] dat, input logic [31:0] msk);
    bus.csr_we = 1; bus.csr_num = 14'(a); bus.csr_wdata = dat; bus.csr_wmask = msk;
    cyc();
    bus.csr_we = 0;
  endtask

  task automatic peek(input int a, output logic [31:0] v);
    bus.csr_re = 1; bus.csr_num = 14'(a);
    #1;
    v = bus.csr_rdata;
    bus.csr_re = 0;
  endtask

  task automatic rdc(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] v;
    peek(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    quiet();
    bus.csr_num = 0; bus.csr_wdata = 0; bus.csr_wmask = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0;
    bus.wb_pc = 0; bus.wb_vaddr = 0; bus.hw_int = 0; bus.ipi_int = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rdc("rst_crmd", 0, 32'h8);
    rdc("rst_eentry", 12, ER);
    rdc("rst_tval", 66, 32'h0);
    chk("rst_has_int", 32'(bus.has_int), 32'h0);
    chk("rst_ex_entry", bus.ex_entry, ER);
    chk("rst_era_pc", bus.era_pc, 32'h0);
    chk("rst_plv_ie", {29'b0, bus.crmd_ie, bus.crmd_plv}, 32'h0);
    @(negedge clk);
    reset = 0;

    wr(50, 32'h12345678, 32'hFFFFFFFF);
    wr(50, 32'hFFFFFFFF, 32'h0000FF00);
    rdc("save2_mask", 50, 32'h1234FF78);
    rdc("save_oob", 48 + NS, 32'h0);
    rdc("unimpl_idle", 2, 32'h0);

    wr(0, 32'h7, 32'h7);
    rdc("crmd_w", 0, 32'hF);
    bus.wb_ex = 1; bus.wb_ecode = 6'h09; bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h1c000100; bus.wb_vaddr = 32'h1003;
    cyc();
    bus.wb_ex = 0;
    rdc("ex_prmd", 1, 32'h7);
    rdc("ex_crmd", 0, 32'h8);
    peek(5, d);
    chk("ex_ecode", (d >> 16) & 32'h3F, 32'h09);
    rdc("ex_era", 6, 32'h1c000100);
    rdc("ex_badv", 7, 32'h1003);
    bus.ertn = 1;
    cyc();
    bus.ertn = 0;
    rdc("ertn_crmd", 0, 32'hF);

    wr(65, 32'h0B, 32'hFFFFFFFF);
    rdc("tval_arm", 66, 32'd8);
    for (int k = 7; k >= 0; k--) begin
      cyc();
      rdc("tval_count", 66, 32'(k));
    end
    cyc();
    rdc("tval_reload", 66, 32'd8);
    peek(5, d);
    chk("is11_set", (d >> 11) & 1, 32'h1);
    wr(68, 32'h1, 32'h1);
    peek(5, d);
    chk("is11_clear", (d >> 11) & 1, 32'h0);
    rdc("ticlr_read", 68, 32'h0);
    for (int g = 0; g < 20 && m[66] != 0; g++) cyc();
    rdc("tval_zero", 66, 32'h0);
    wr(68, 32'h1, 32'h1);
    peek(5, d);
    chk("is11_set_wins", (d >> 11) & 1, 32'h1);
    rdc("tval_reload2", 66, 32'd8);

    wr(65, 32'h0, 32'hFFFFFFFF);
    wr(68, 32'h1, 32'h1);
    peek(5, d);
    chk("is11_pre_oneshot", (d >> 11) & 1, 32'h0);
    wr(65, 32'h05, 32'hFFFFFFFF);
    n = 0;
    for (int g = 1; g <= 20; g++) begin
      cyc();
      peek(5, d);
      if (d[11]) begin
        n = g;
        break;
      end
    end
    chk("oneshot_latency", 32'(n), 32'd5);
    rdc("oneshot_tcfg", 65, 32'h4);
    rdc("oneshot_tval", 66, 32'h0);
    wr(68, 32'h1, 32'h1);
    repeat (10) cyc();
    peek(5, d);
    chk("oneshot_single", (d >> 11) & 1, 32'h0);
    rdc("oneshot_hold", 66, 32'h0);

    wr(4, 32'h8, 32'hFFFFFFFF);
    wr(0, 32'h4, 32'h4);
    bus.hw_int = 8'h02;
    cyc();
    bus.hw_int = 8'h00;
    chk("has_int_pulse", 32'(bus.has_int), 32'h1);
    cyc();
    chk("has_int_drop", 32'(bus.has_int), 32'h0);
    bus.csr_we = 1; bus.csr_num = 0; bus.csr_wdata = 32'h3; bus.csr_wmask = 32'hF;
    bus.wb_ex = 1; bus.wb_ecode = 6'h00; bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h1c000200; bus.wb_vaddr = 32'h5555;
    cyc();
    quiet();
    rdc("prio_crmd", 0, 32'h8);
    rdc("prio_prmd", 1, 32'h7);
    rdc("prio_era", 6, 32'h1c000200);
    rdc("prio_badv", 7, 32'h1003);

    for (int r = 0; r < 400; r++) begin
      bus.csr_we = 1'($urandom_range(0, 1));
      bus.csr_num = 14'(alist[$urandom_range(0, 17)]);
      bus.csr_wdata = $urandom;
      bus.csr_wmask = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom;
      if (bus.csr_num == 14'h41 && bus.csr_wdata[TW-1:8] != 0) bus.csr_wdata[TW-1:8] = 0;
      bus.wb_ex = ($urandom_range(0, 15) == 0);
      bus.ertn = ($urandom_range(0, 15) == 0);
      bus.wb_ecode = 6'($urandom_range(0, 12));
      bus.wb_esubcode = 9'($urandom);
      bus.wb_pc = $urandom;
      bus.wb_vaddr = $urandom;
      bus.hw_int = 8'($urandom);
      bus.ipi_int = 1'($urandom_range(0, 1));
      cyc();
      quiet();
      peek(alist[$urandom_range(0, 17)], d);
      chk("rand_read", d, mread(int'(bus.csr_num)));
    end

    bus.hw_int = 0; bus.ipi_int = 0;
    wr(65, 32'h41, 32'hFFFFFFFF);
    repeat (5) cyc();
    @(negedge clk);
    reset = 1;
    #1;
    rdc("async_tval", 66, 32'h0);
    rdc("async_crmd", 0, 32'h8);
    chk("async_ex_entry", bus.ex_entry, ER);
    chk("async_has_int", 32'(bus.has_int), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
    cyc();
    rdc("post_rst_tval", 66, 32'h0);
    rdc("post_rst_tcfg", 65, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
